onfi_feature_req_ctrl: RTL and testbench

Host-side request controller that sits directly upstream of the GET FEATURES engine. It accepts one feature-read request at a time from the host over a valid/ready interface and launches the engine with a one-cycle start pulse. It then waits for the engine's completion, with an optional timeout, and returns the 32-bit feature data over a valid/ready response channel. An enforced idle gap follows each completed transaction so that back-to-back feature reads respect the NAND recovery time.

---
 rtl/onfi_feature_req_ctrl.sv | 125 ++++++++++++
 tb/tb_onfi_feature_req_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/onfi_feature_req_ctrl.sv
// rtl/onfi_feature_req_ctrl.sv - single-request GET FEATURES launcher with timeout and recovery gap
// ONFI_FEAT_TIMEOUT_EN compiles in the WAIT timeout counter and the error response path.
module onfi_feature_req_ctrl #(
  parameter int ONFI_FRE    = 200,
  parameter int TIMEOUT_CYC = 1024,
  parameter int GAP_CYC     = (ONFI_FRE * 100) / 1000
) (
  input  logic        onfi_clk,
  input  logic        onfi_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        gf_start,
  output logic [31:0] gf_addr,
  input  logic        gf_done,
  input  logic [31:0] gf_data,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RESP,
    S_GAP
  } state_t;

  localparam bit          GAP_EN   = (GAP_CYC > 0);
  localparam logic [31:0] GAP_LAST = (GAP_CYC > 0) ? 32'(GAP_CYC - 1) : 32'd0;

  state_t      state_q;
  logic [7:0]  addr_q;
  logic        gf_start_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_data_q;
  logic [31:0] gap_cnt_q;
`ifdef ONFI_FEAT_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
  logic [15:0] to_cnt_q;
  logic        rsp_err_q;
`endif

  always_ff @(posedge onfi_clk) begin
    if (onfi_rst) begin
      state_q     <= S_IDLE;
      addr_q      <= 8'h00;
      gf_start_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'h0;
      gap_cnt_q   <= 32'h0;
`ifdef ONFI_FEAT_TIMEOUT_EN
      to_cnt_q    <= 16'h0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      gf_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            addr_q     <= req_addr;
            gf_start_q <= 1'b1;
            state_q    <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
`ifdef ONFI_FEAT_TIMEOUT_EN
          to_cnt_q <= 16'h0;
`endif
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // done is checked first so a completion on the timeout cycle still returns data
          if (gf_done) begin
            rsp_data_q  <= gf_data;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
`ifdef ONFI_FEAT_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
          end else if (to_cnt_q == TO_LAST) begin
            rsp_data_q  <= 32'hFFFF_FFFF;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else if (to_cnt_q != 16'hFFFF) begin
            to_cnt_q <= to_cnt_q + 16'd1;
`endif
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            gap_cnt_q   <= 32'h0;
            state_q     <= GAP_EN ? S_GAP : S_IDLE;
          end
        end
        S_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            state_q <= S_IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + 32'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Reset masks the handshake-visible outputs in the same cycle it is asserted.
  assign req_ready = (state_q == S_IDLE) && !onfi_rst;
  assign gf_start  = gf_start_q && !onfi_rst;
  assign rsp_valid = rsp_valid_q && !onfi_rst;
  assign rsp_data  = rsp_data_q;
  assign gf_addr   = {24'h0, addr_q};
  assign busy      = (state_q != S_IDLE);
`ifdef ONFI_FEAT_TIMEOUT_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_onfi_feature_req_ctrl.sv
// tb/tb_onfi_feature_req_ctrl.sv - directed and randomized bench for onfi_feature_req_ctrl
module tb_onfi_feature_req_ctrl;

  localparam int T   = 16;
  localparam int GAP = 20;
`ifdef ONFI_FEAT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        onfi_rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [7:0]  req_addr = 8'h00;
  logic        rsp_ready = 1'b0;
  logic        gf_done = 1'b0;
  logic [31:0] gf_data = 32'h0;
  logic        req_ready, rsp_valid, rsp_err, gf_start, busy;
  logic [31:0] rsp_data, gf_addr;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          eng_k = 2;
  logic [31:0] eng_data = 32'h0;
  int          last_r = 0;

  onfi_feature_req_ctrl #(
    .ONFI_FRE(200),
    .TIMEOUT_CYC(T),
    .GAP_CYC(GAP)
  ) dut (
    .onfi_clk(clk),
    .onfi_rst(onfi_rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr(req_addr),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data(rsp_data),
    .rsp_err(rsp_err),
    .gf_start(gf_start),
    .gf_addr(gf_addr),
    .gf_done(gf_done),
    .gf_data(gf_data),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Engine model: answers eng_k edges after the edge that launched it, aborts on reset.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (gf_start === 1'b1 && !onfi_rst) begin
        bit abort;
        abort = 1'b0;
        for (int j = 0; j < eng_k - 1; j++) begin
          @(posedge clk);
          #2;
          if (onfi_rst) begin
            abort = 1'b1;
            break;
          end
        end
        if (!abort) begin
          gf_done = 1'b1;
          gf_data = eng_data;
          @(posedge clk);
          #2;
          gf_done = 1'b0;
          gf_data = $urandom;
        end
      end
    end
  end

  task automatic txn(input logic [7:0] addr, input int k, input logic [31:0] data,
                     input int bp, input bit hold, input bit b2b);
    int g, r, n, starts, exp_lat;
    logic [31:0] exp_data;
    logic exp_err;
    bit to;
    eng_k = k;
    eng_data = data;
    req_addr = addr;
    req_valid = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 200) begin step(); n++; end
    chk("accept_in_budget", 32'(n < 200), 32'd1);
    step();
    g = cyc;
    if (!hold) req_valid = 1'b0;
    if (b2b) chk("b2b_accept_gap", g - last_r, GAP + 1);
    chk("gf_start", 32'(gf_start), 32'd1);
    chk("gf_addr", gf_addr, {24'h0, addr});
    chk("busy", 32'(busy), 32'd1);
    chk("req_ready_busy", 32'(req_ready), 32'd0);
    // Response arrives k edges after launch, or T+1 edges if the engine is later than that.
    to = TO_EN && (k > T + 1);
    exp_lat  = to ? T + 1 : k;
    exp_data = to ? 32'hFFFF_FFFF : data;
    exp_err  = to;
    starts = 0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 200) begin
      step();
      n++;
      if (gf_start === 1'b1) starts++;
    end
    chk("rsp_latency", cyc - g, exp_lat);
    chk("rsp_data", rsp_data, exp_data);
    chk("rsp_err", 32'(rsp_err), 32'(exp_err));
    for (int i = 0; i < bp; i++) begin
      step();
      if (gf_start === 1'b1) starts++;
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_data", rsp_data, exp_data);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    r = cyc;
    chk("rsp_drop", 32'(rsp_valid), 32'd0);
    n = 0;
    while (req_ready !== 1'b1 && n < 200) begin
      if (rsp_valid === 1'b1 || gf_start === 1'b1) starts++;
      step();
      n++;
    end
    chk("gap_len", cyc - r, GAP);
    chk("no_extra_activity", starts, 0);
    chk("hold_data", rsp_data, exp_data);
    chk("hold_err", 32'(rsp_err), 32'(exp_err));
    last_r = r;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k;
    logic [31:0] d;
    bit h, prev;

    onfi_rst = 1'b1;
    step();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_gf_start", 32'(gf_start), 32'd0);
    chk("rst_gf_addr", gf_addr, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    step();
    onfi_rst = 1'b0;
    #1;
    chk("idle_req_ready", 32'(req_ready), 32'd1);

    txn(8'h01, 6, 32'h0000_0005, 0, 1'b0, 1'b0);
    txn(8'h22, 4, 32'hDEAD_BEEF, 10, 1'b0, 1'b0);
    txn(8'h33, T + 1, 32'hCAFE_F00D, 0, 1'b0, 1'b0);
`ifdef ONFI_FEAT_TIMEOUT_EN
    txn(8'h7E, T + 6, 32'h1234_5678, 2, 1'b0, 1'b0);
`endif
    txn(8'h40, 3, 32'h0BAD_F00D, 0, 1'b1, 1'b0);
    txn(8'h41, 5, 32'h0000_4141, 0, 1'b0, 1'b1);

    eng_k = 60;
    req_addr = 8'h66;
    req_valid = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 200) begin step(); n++; end
    step();
    req_valid = 1'b0;
    chk("rw_gf_start", 32'(gf_start), 32'd1);
    repeat (5) step();
    onfi_rst = 1'b1;
    #1;
    chk("rw_valid_in_rst", 32'(rsp_valid), 32'd0);
    chk("rw_ready_in_rst", 32'(req_ready), 32'd0);
    step();
    onfi_rst = 1'b0;
    #1;
    chk("rw_busy", 32'(busy), 32'd0);
    chk("rw_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rw_req_ready", 32'(req_ready), 32'd1);
    chk("rw_gf_addr", gf_addr, 32'h0);
    txn(8'h55, 7, 32'h5555_AAAA, 1, 1'b0, 1'b0);

    prev = 1'b0;
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(2, T + 6);
      d = $urandom;
      h = (i < 39) ? 1'($urandom_range(0, 1)) : 1'b0;
      txn(8'($urandom), k, d, $urandom_range(0, 3), h, prev);
      prev = h;
    end
    req_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
